// File: rtl/line_window_buf.sv
// K x K sliding-window generator over a raster pixel stream, K-1 line memories deep.
// Latency: a window is registered one cycle after the pixel that completes it is accepted.
// Backpressure: s_ready = !m_valid || m_ready; the window register holds while stalled.
module line_window_buf #(
    parameter int DW    = 8,
    parameter int MAX_W = 2048,
    parameter int AW    = 11,
    parameter int K     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AW:0]           cfg_width,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DW-1:0]         s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [K*K*DW-1:0]     m_win,
    output logic                  m_last
);

    localparam logic [AW:0]   K_W     = (AW+1)'(K);
    localparam logic [AW:0]   MAX_W_W = (AW+1)'(MAX_W);
    localparam logic [AW:0]   ONE_W   = (AW+1)'(1);
    localparam logic [AW-1:0] KM1_X   = AW'(K-1);
    localparam logic [2:0]    KM1_Y   = 3'(K-1);

    logic [AW-1:0]    x;
    logic [2:0]       y;
    logic             in_frame;
    logic [AW:0]      wid;
    logic [AW:0]      cfg_clamped;
    logic             acc;
    logic             produce;
    logic             x_wrap;
    logic [DW-1:0]    rd    [K-1];
    logic [DW-1:0]    col   [K];
    logic [DW-1:0]    shreg [K][K-1];
    logic [K*K*DW-1:0] win;

    assign s_ready = !m_valid || m_ready;
    assign acc     = s_valid && s_ready;
    // x never wraps at column 0 (width >= K >= 3), so the stale width is harmless on the first pixel
    assign x_wrap  = ({1'b0, x} == (wid - ONE_W));
    assign produce = acc && (y == KM1_Y) && (x >= KM1_X);

    // Clamp the requested width into [K, MAX_W]
    always_comb begin
        cfg_clamped = cfg_width;
        if (cfg_width < K_W) begin
            cfg_clamped = K_W;
        end else if (cfg_width > MAX_W_W) begin
            cfg_clamped = MAX_W_W;
        end
    end

    // Raster position and per-frame width latch; s_last restarts the frame from (0,0)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x        <= '0;
            y        <= '0;
            in_frame <= 1'b0;
            wid      <= K_W;
        end else if (acc) begin
            if (!in_frame) begin
                wid <= cfg_clamped;
            end
            if (s_last) begin
                x        <= '0;
                y        <= '0;
                in_frame <= 1'b0;
            end else begin
                in_frame <= 1'b1;
                if (x_wrap) begin
                    x <= '0;
                    if (y != KM1_Y) begin
                        y <= y + 3'd1;
                    end
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end

    // Line memory chain: memory 0 holds the previous line, memory i the line i+1 rows back.
    // Reads are asynchronous, so each write stores the value read from its predecessor this cycle.
    for (genvar i = 0; i < K-1; i++) begin : g_line
        logic [DW-1:0] ram [MAX_W];
        assign rd[i] = ram[x];
        if (i == 0) begin : g_head
            // Newest line takes the incoming pixel
            always_ff @(posedge clk) begin
                if (acc) begin
                    ram[x] <= s_data;
                end
            end
        end else begin : g_tail
            // Older lines take the line displaced from the memory in front
            always_ff @(posedge clk) begin
                if (acc) begin
                    ram[x] <= rd[i-1];
                end
            end
        end
    end

    // Current column of K pixels, row 0 oldest
    always_comb begin
        col[K-1] = s_data;
        for (int r = 0; r < K-1; r++) begin
            col[r] = rd[K-2-r];
        end
    end

    // Per-row shift register of the K-1 previous columns; contents before column K-1 are never used
    always_ff @(posedge clk) begin
        if (acc) begin
            for (int r = 0; r < K; r++) begin
                shreg[r][0] <= col[r];
                for (int j = 1; j < K-1; j++) begin
                    shreg[r][j] <= shreg[r][j-1];
                end
            end
        end
    end

    // Assemble the window, element (r,c) at [(r*K+c)*DW +: DW], c=0 oldest column
    always_comb begin
        win = '0;
        for (int r = 0; r < K; r++) begin
            win[(r*K+K-1)*DW +: DW] = col[r];
            for (int c = 0; c < K-1; c++) begin
                win[(r*K+c)*DW +: DW] = shreg[r][K-2-c];
            end
        end
    end

    // Output register: a new window replaces the old one even while it drains
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_win   <= '0;
        end else if (produce) begin
            m_valid <= 1'b1;
            m_last  <= s_last;
            m_win   <= win;
        end else if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_line_window_buf.sv
// Bench for line_window_buf: K=3 and K=5 instances, table vectors, hand sequences, random frames.
// Expected windows come from a frame-level model (pixel index -> row/column of the clamped width).
// Monitor checks every handshake, the s_ready rule and output stability during stalls.
module tb_line_window_buf;

    localparam int DW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        s_valid;
    logic        s_last;
    logic [7:0]  s_data;
    logic [11:0] cfg;
    logic        m_ready;

    logic        sv3, sr3, mv3, ml3;
    logic [71:0] mw3;
    logic        sv5, sr5, mv5, ml5;
    logic [199:0] mw5;

    logic        sr, mv, ml;
    logic [199:0] mw;

    always #5 clk = ~clk;

    assign sv3 = s_valid && !sel;
    assign sv5 = s_valid && sel;
    assign sr  = sel ? sr5 : sr3;
    assign mv  = sel ? mv5 : mv3;
    assign ml  = sel ? ml5 : ml3;
    assign mw  = sel ? mw5 : {128'b0, mw3};

    line_window_buf #(.DW(8), .MAX_W(2048), .AW(11), .K(3)) dut3 (
        .clk(clk), .rst(rst), .cfg_width(cfg), .s_valid(sv3), .s_ready(sr3),
        .s_data(s_data), .s_last(s_last), .m_valid(mv3), .m_ready(m_ready),
        .m_win(mw3), .m_last(ml3)
    );

    line_window_buf #(.DW(8), .MAX_W(64), .AW(6), .K(5)) dut5 (
        .clk(clk), .rst(rst), .cfg_width(cfg[6:0]), .s_valid(sv5), .s_ready(sr5),
        .s_data(s_data), .s_last(s_last), .m_valid(mv5), .m_ready(m_ready),
        .m_win(mw5), .m_last(ml5)
    );

    typedef struct packed {
        logic [199:0] win;
        logic         last;
    } wexp_t;

    typedef struct {
        int s;
        int wcfg;
        int npix;
        int rmode;
        int pmode;
        int exp_win;
    } vec_t;

    int           checks = 0;
    int           failures = 0;
    int           rmode = 0;
    wexp_t        expq[$];
    logic [199:0] obs[$];
    logic [7:0]   pix[$];

    localparam logic [199:0] FIRST3 = 200'h222120121110020100;
    localparam logic [199:0] FIRST5 = 200'h44434241403433323130242322212014131211100403020100;

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int weff_of(input int s, input int wcfg);
        int kk = (s != 0) ? 5 : 3;
        int mx = (s != 0) ? 64 : 2048;
        if (wcfg < kk) return kk;
        if (wcfg > mx) return mx;
        return wcfg;
    endfunction

    task automatic gen_pix(input int weff, input int npix, input int pmode);
        pix.delete();
        for (int i = 0; i < npix; i++) begin
            if (pmode == 0) pix.push_back(8'((i / weff) * 16 + (i % weff)));
            else            pix.push_back(8'($urandom));
        end
    endtask

    // Frame-level model: pixel i sits at row i/W, column i%W; windows need K-1 rows/cols behind them
    task automatic model_frame(input int s, input int wcfg, input int npix, input int has_last);
        int    kk = (s != 0) ? 5 : 3;
        int    weff = weff_of(s, wcfg);
        wexp_t e;
        for (int i = 0; i < npix; i++) begin
            int row = i / weff;
            int cl  = i % weff;
            if (row >= kk-1 && cl >= kk-1) begin
                e.win = '0;
                for (int r = 0; r < kk; r++)
                    for (int c = 0; c < kk; c++)
                        e.win[(r*kk+c)*8 +: 8] = pix[(row-kk+1+r)*weff + cl-kk+1+c];
                e.last = (has_last != 0) && (i == npix-1);
                expq.push_back(e);
            end
        end
    endtask

    task automatic send_frame(input int s, input int wcfg, input int npix, input int has_last);
        bit accepted;
        sel = (s != 0);
        cfg = 12'(wcfg);
        for (int i = 0; i < npix; i++) begin
            s_valid  = 1'b1;
            s_data   = pix[i];
            s_last   = (has_last != 0) && (i == npix-1);
            accepted = 1'b0;
            for (int t = 0; t < 300 && !accepted; t++) begin
                @(negedge clk);
                accepted = sr;
                @(posedge clk);
                #1;
            end
            if (!accepted) check("accept_timeout", 1'b0, 1'b1);
            if (i == 0) cfg = 12'($urandom);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 4000 && expq.size() != 0; t++) @(posedge clk);
        if (expq.size() != 0) begin
            check("drain_timeout", 200'(expq.size()), 200'd0);
            expq.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Downstream ready pattern
    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       m_ready = 1'b1;
            1:       m_ready = ~m_ready;
            2:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
    end

    logic         prev_stall = 1'b0;
    logic [199:0] prev_win;
    logic         prev_last;
    wexp_t        me;

    // Output monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            check("s_ready_rule", sr, !mv || m_ready);
            if (prev_stall) begin
                check("stall_valid", mv, 1'b1);
                check("stall_win", mw, prev_win);
                check("stall_last", ml, prev_last);
            end
            if (mv && m_ready) begin
                if (expq.size() == 0) begin
                    check("unexpected_window", mw, 200'd0);
                end else begin
                    me = expq.pop_front();
                    check("win", mw, me.win);
                    check("last", ml, me.last);
                end
                obs.push_back(mw);
            end
            prev_stall = mv && !m_ready;
            prev_win   = mw;
            prev_last  = ml;
        end
    end

    initial begin
        #5000000;
        failures++;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    vec_t tbl[8];

    initial begin
        rst = 1'b1; sel = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        cfg = 12'd5; m_ready = 1'b1;
        tbl[0] = '{0, 5,   20,  0, 0, 6};
        tbl[1] = '{0, 5,   20,  1, 0, 6};
        tbl[2] = '{0, 2,   9,   0, 0, 1};
        tbl[3] = '{1, 6,   36,  0, 0, 4};
        tbl[4] = '{0, 12,  36,  2, 1, 10};
        tbl[5] = '{1, 100, 320, 2, 1, 60};
        tbl[6] = '{0, 4,   11,  1, 0, 1};
        tbl[7] = '{0, 0,   9,   2, 0, 1};

        #1;
        check("rst_m_valid", mv3, 1'b0);
        check("rst_m_last", ml3, 1'b0);
        check("rst_m_win", mw3, 200'd0);
        check("rst_s_ready", sr3, 1'b1);
        check("rst_m_valid_k5", mv5, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int v = 0; v < 8; v++) begin
            rmode = tbl[v].rmode;
            obs.delete();
            gen_pix(weff_of(tbl[v].s, tbl[v].wcfg), tbl[v].npix, tbl[v].pmode);
            model_frame(tbl[v].s, tbl[v].wcfg, tbl[v].npix, 1);
            send_frame(tbl[v].s, tbl[v].wcfg, tbl[v].npix, 1);
            wait_drain();
            check($sformatf("win_count_%0d", v), 200'(obs.size()), 200'(tbl[v].exp_win));
            if (tbl[v].pmode == 0 && obs.size() > 0)
                check($sformatf("first_win_%0d", v), obs[0], (tbl[v].s != 0) ? FIRST5 : FIRST3);
        end

        // Back-to-back frames of different widths, no idle cycle between them
        rmode = 0;
        obs.delete();
        gen_pix(5, 15, 0);
        model_frame(0, 5, 15, 1);
        begin
            logic [7:0] keep[$];
            keep = pix;
            gen_pix(8, 24, 0);
            model_frame(0, 8, 24, 1);
            begin
                logic [7:0] second[$];
                second = pix;
                pix = keep;
                send_frame(0, 5, 15, 1);
                pix = second;
                send_frame(0, 8, 24, 1);
            end
        end
        wait_drain();
        check("b2b_count", 200'(obs.size()), 200'd9);
        if (obs.size() == 9) begin
            check("b2b_f1_last_px", obs[2][71:64], 8'h24);
            check("b2b_f2_first", obs[3], FIRST3);
        end

        // Reset while a window is held by a stalled consumer
        rmode = 3;
        repeat (2) @(posedge clk);
        #1;
        gen_pix(5, 13, 0);
        send_frame(0, 5, 13, 0);
        check("pre_reset_valid", mv3, 1'b1);
        rst = 1'b1;
        #1;
        check("reset_drop_valid", mv3, 1'b0);
        check("reset_drop_win", mw3, 200'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        rmode = 0;
        obs.delete();
        gen_pix(5, 20, 0);
        model_frame(0, 5, 20, 1);
        send_frame(0, 5, 20, 1);
        wait_drain();
        check("post_reset_count", 200'(obs.size()), 200'd6);
        if (obs.size() > 0) check("post_reset_first", obs[0], FIRST3);

        // Random frames, random widths, early s_last and random backpressure
        for (int n = 0; n < 12; n++) begin
            int s, wcfg, weff, npix, nm;
            s    = int'($urandom_range(0, 1));
            wcfg = int'($urandom_range(0, 12));
            weff = weff_of(s, wcfg);
            npix = weff * int'($urandom_range(1, 7));
            if ($urandom_range(0, 3) == 0) npix = int'($urandom_range(1, npix));
            rmode = int'($urandom_range(0, 2));
            obs.delete();
            gen_pix(weff, npix, 1);
            model_frame(s, wcfg, npix, 1);
            nm = expq.size();
            send_frame(s, wcfg, npix, 1);
            wait_drain();
            check($sformatf("rand_count_%0d", n), 200'(obs.size()), 200'(nm));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
